// File: rtl/sopc_v3_pkg.sv
// Shared constants for the limit-switch PIO slave: bus width and register map.
package sopc_v3_pkg;

    localparam int BUS_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/sopc_v3_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability counter.
// The debounced level only moves after DEBOUNCE_CYCLES consecutive cycles of
// disagreement. edge_pulse is a one-cycle strobe that is coincident with the
// level update.
module sopc_v3_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic edge_pulse
);

    // Enough bits to count 0 .. DEBOUNCE_CYCLES-1.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1_reg;
    logic             sync_2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             edge_reg;

    // Synchronize, then count cycles where the synced level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1_reg <= 1'b0;
            sync_2_reg <= 1'b0;
            cnt_reg    <= '0;
            level_reg  <= 1'b0;
            edge_reg   <= 1'b0;
        end else begin
            sync_1_reg <= raw;
            sync_2_reg <= sync_1_reg;
            edge_reg   <= 1'b0;
            if (sync_2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                level_reg <= sync_2_reg;
                cnt_reg   <= '0;
                edge_reg  <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level      = level_reg;
    assign edge_pulse = edge_reg;

endmodule

// File: rtl/sopc_v3_fin_course.sv
// Avalon-MM slave for end-of-travel limit switches: debounced levels,
// per-bit edge capture with write-1-to-clear, interrupt mask and level irq.
module sopc_v3_fin_course
    import sopc_v3_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] level_bus;
    logic [WIDTH-1:0] edge_bus;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] clear_mask;
    logic [BUS_W-1:0] readdata_reg;
    logic [BUS_W-1:0] read_mux;
    logic             bus_write;
    logic             bus_read;
    logic             unused_wdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            sopc_v3_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .reset_n   (reset_n),
                .raw       (in_port[gi]),
                .level     (level_bus[gi]),
                .edge_pulse(edge_bus[gi])
            );
        end
    endgenerate

    assign bus_write    = chipselect && !write_n;
    assign bus_read     = chipselect && write_n;
    // Upper write-data bits have no storage; fold them so the whole port is consumed.
    assign unused_wdata = ^writedata;

    // Edge capture: clear requested bits, then OR in new edges so a fresh edge beats a clear.
    always_comb begin
        clear_mask = '0;
        if (bus_write && address == ADDR_EDGECAP) begin
            clear_mask = writedata[WIDTH-1:0];
        end
        edgecap_next = (edgecap_reg & ~clear_mask) | edge_bus;
    end

    // Read mux, zero-extended to the bus width; reserved address reads as zero.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:    read_mux[WIDTH-1:0] = level_bus;
            ADDR_IRQMASK: read_mux[WIDTH-1:0] = irqmask_reg;
            ADDR_EDGECAP: read_mux[WIDTH-1:0] = edgecap_reg;
            default:      read_mux = '0;
        endcase
    end

    // Register file state and registered read data (held between reads).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            readdata_reg <= '0;
        end else begin
            edgecap_reg <= edgecap_next;
            if (bus_write && address == ADDR_IRQMASK) begin
                irqmask_reg <= writedata[WIDTH-1:0];
            end
            if (bus_read) begin
                readdata_reg <= read_mux;
            end
        end
    end

    assign readdata = readdata_reg;
    // Pure function of two registers, so no path from bus or switch inputs.
    assign irq      = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_sopc_v3_fin_course.sv
// Scoreboard bench for the limit-switch slave with DEBOUNCE_CYCLES=4.
// Reads push the expected readdata; a monitor compares one cycle after the strobe.
module tb_sopc_v3_fin_course;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [1:0]  in_port = 2'b00;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] val;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    sopc_v3_fin_course #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Monitor: a read strobe seen at a rising edge produces readdata checked at the next falling edge.
    initial begin
        logic strobe;
        exp_t e;
        forever begin
            @(posedge clk);
            strobe = chipselect && write_n;
            @(negedge clk);
            if (strobe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read actual=0x%08h required=none", readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (readdata !== e.val) begin
                        failures++;
                        $display("FAIL %s actual=0x%08h required=0x%08h", e.nm, readdata, e.val);
                    end else begin
                        $display("ok   %s readdata=0x%08h", e.nm, readdata);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        exp_t e;
        e.val = exp;
        e.nm  = nm;
        exp_q.push_back(e);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        cyc();
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("wr   addr=%0d data=0x%08h", a, d);
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        checks++;
        if (irq !== exp) begin
            failures++;
            $display("FAIL %s irq actual=%b required=%b", nm, irq, exp);
        end else begin
            $display("ok   %s irq=%b", nm, irq);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(3);
        chk_irq(1'b0, "irq_in_reset");
        reset_n = 1'b1;
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd2, 32'h0, "rst_irqmask");
        rd(2'd3, 32'h0, "rst_edgecap");
        rd(2'd1, 32'h0, "rst_reserved");
        chk_irq(1'b0, "irq_after_reset");

        // Bit0 rises; DATA register flips 6 edges after the change, visible on the 7th read
        in_port = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, (i >= 7) ? 32'h1 : 32'h0, $sformatf("latency_read_%0d", i));
        end
        rd(2'd3, 32'h1, "edgecap_bit0");
        chk_irq(1'b0, "irq_masked");

        // 3-cycle glitch on bit1 must be ignored
        in_port = 2'b11;
        idle(3);
        in_port = 2'b01;
        idle(8);
        rd(2'd0, 32'h1, "glitch_data");
        rd(2'd3, 32'h1, "glitch_edgecap");

        // Writes to read-only / reserved addresses are ignored
        wr(2'd0, 32'h3);
        rd(2'd0, 32'h1, "data_readonly");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, "reserved_zero");

        // Mask and write-1-to-clear
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h3, "irqmask_width");
        chk_irq(1'b1, "irq_unmasked");
        wr(2'd3, 32'h2);
        chk_irq(1'b1, "irq_clear_other_bit");
        rd(2'd3, 32'h1, "edgecap_after_clr2");
        wr(2'd3, 32'h1);
        chk_irq(1'b0, "irq_cleared");
        rd(2'd3, 32'h0, "edgecap_cleared");

        // Bit1 edge lands in the same cycle as a clear of bit1: set wins
        in_port = 2'b11;
        idle(6);
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h2, "set_beats_clear");
        chk_irq(1'b1, "irq_set_beats_clear");
        rd(2'd0, 32'h3, "data_both");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "edgecap_clear_bit1");

        // Reset mid-count discards the partial debounce
        reset_n = 1'b0;
        in_port = 2'b00;
        idle(3);
        reset_n = 1'b1;
        in_port = 2'b11;
        idle(3);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, (i >= 7) ? 32'h3 : 32'h0, $sformatf("rst_mid_read_%0d", i));
        end
        rd(2'd3, 32'h3, "rst_mid_edgecap");
        rd(2'd2, 32'h0, "rst_mid_irqmask");
        chk_irq(1'b0, "irq_rst_mid");

        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_reads actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sopc_v3_fin_course.md
SOPC_V3_FIN_COURSE -- requirements
Module: sopc_v3_fin_course

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of limit-switch input bits (bit0 = retracted, bit1 = extended).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable clk cycles required to accept a new input level; legal range 2..2^20.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  write strobe, active-low; read = chipselect && write_n.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port in_port  input  WIDTH  raw asynchronous switch levels.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-012 Register map: addr 0 = DATA (debounced levels, read-only; writes ignored); addr 1 = reserved (reads 0, writes ignored); addr 2 = IRQMASK (R/W, bits WIDTH-1:0); addr 3 = EDGECAP (read; write-1-to-clear per bit).
REQ-013 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per bit: counter SHALL reset to 0 whenever synced level equals debounced level, else increment; when it reaches DEBOUNCE_CYCLES-1 the debounced bit SHALL take the synced level next cycle and the counter SHALL clear.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the debounced bit.
REQ-016 Total latency from in_port change (stable) to DATA change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-017 EDGECAP bit SHALL set on the cycle after any debounced transition (rising or falling) of that bit and hold until cleared.
REQ-018 Write to addr 3 with writedata[i]=1 SHALL clear EDGECAP[i]; bits written 0 unchanged.
REQ-019 Simultaneous edge-set and clear on the same bit in the same cycle: set SHALL win.
REQ-020 irq SHALL equal OR over i of (EDGECAP[i] & IRQMASK[i]), driven from registers with no combinational path from in_port or bus inputs.
REQ-021 Reads: readdata SHALL present the addressed register zero-extended to 32 bits one cycle after the read strobe (read latency 1); when no read occurs readdata SHALL hold its previous value.
REQ-022 Reads SHALL have no side effects; no waitrequest, slave is always ready.
REQ-023 Write to IRQMASK SHALL take effect on irq in the next cycle.

Reset
REQ-024 While reset_n=0 at a clk edge: synchronizers, counters, DATA, IRQMASK, EDGECAP, readdata SHALL clear to 0; irq SHALL be 0 the cycle after.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release a switch already at 1 SHALL appear in DATA after DEBOUNCE_CYCLES+2 cycles and SHALL set EDGECAP (0->1 transition).

Structure
REQ-026 Shared package sopc_v3_pkg SHALL hold register address constants (ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP) and bus width constant (32).
REQ-027 Synchronizer plus debounce counter SHALL be one sub-module, sopc_v3_debounce, instantiated WIDTH times; counter width derived from DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-028 Reset then read addr 0, 2, 3 -> readdata 0x0 each, one cycle after strobe; irq=0.
REQ-029 in_port 00->01 held -> DATA=0x1 exactly 6 cycles later; EDGECAP=0x1 the following cycle; irq stays 0 (mask 0).
REQ-030 in_port[1] pulses high 3 cycles -> DATA, EDGECAP unchanged at 0.
REQ-031 IRQMASK=0x3, bit0 edge captured -> irq=1; write 0x2 to addr 3 -> irq stays 1; write 0x1 -> irq=0 next cycle.
REQ-032 Debounced edge on bit1 in the same cycle as write 0x2 to addr 3 -> EDGECAP[1] remains 1.
REQ-033 in_port=11 with reset_n pulsed low mid-count -> after release DATA=0x3 after exactly 6 cycles, EDGECAP=0x3.
